pipe_regfile: RTL and testbench

//  Multi-port register file for the pipelined datapath: NREAD combinational read ports, NWRITE

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/pipe_regfile.sv | 88 ++++++++
 tb/tb_pipe_regfile.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the pipelined register file.
// No logic of its own; pure compile-time definitions.
// No handshake; consumers import what they need.
package regfile_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AW_DEF    = 4;

    typedef logic [AW_DEF-1:0]    reg_addr_t;
    typedef logic [WIDTH_DEF-1:0] word_t;

    // The top architectural address is aliased to the program counter.
    function automatic int pc_reg_idx(input int regnum);
        return regnum - 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register with an outstanding producer.
// Write-hit vector is combinational; pending updates one cycle after issue/write.
// No backpressure: issue and writeback are accepted every cycle unconditionally.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGNUM = 16,
    parameter int AW     = 4,
    parameter int NWRITE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWRITE-1:0]    we,
    input  logic [NWRITE*AW-1:0] wa,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_dst,
    output logic [REGNUM-1:0]    pending,
    output logic [REGNUM-1:0]    whit
);

    localparam logic [AW-1:0] PC_REG = AW'(pc_reg_idx(REGNUM));

    logic [REGNUM-1:0] pend_nxt;

    // Decode every active write port into a per-register hit mask.
    always_comb begin
        whit = '0;
        for (int w = 0; w < NWRITE; w++) begin
            if (we[w]) begin
                whit[wa[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Writes retire producers; a same-cycle issue re-arms the bit (set beats clear).
    always_comb begin
        pend_nxt = pending & ~whit;
        if (issue_en && (issue_dst != PC_REG)) begin
            pend_nxt[issue_dst] = 1'b1;
        end
    end

    // Pending state register; reset drops every in-flight producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// Multi-port register file with write bypass, PC alias on the top address, and busy flags.
// Reads are combinational (zero latency); writes land at the next rising edge.
// No backpressure: busy is advisory so decode can stall; writes are always accepted.
module pipe_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REGNUM    = 16,
    parameter int AW        = 4,
    parameter int NREAD     = 3,
    parameter int NWRITE    = 2,
    parameter int PC_OFFSET = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic [NREAD-1:0]        busy,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    wa,
    input  logic [NWRITE*WIDTH-1:0] wd,
    input  logic [WIDTH-1:0]        pc,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_dst
);

    localparam logic [AW-1:0]    PC_REG = AW'(pc_reg_idx(REGNUM));
    localparam logic [WIDTH-1:0] PC_ADD = WIDTH'(PC_OFFSET);

    logic [WIDTH-1:0]  rf [REGNUM];
    logic [REGNUM-1:0] pending;
    logic [REGNUM-1:0] whit;

    rf_scoreboard #(
        .REGNUM (REGNUM),
        .AW     (AW),
        .NWRITE (NWRITE)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wa        (wa),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .pending   (pending),
        .whit      (whit)
    );

    // Storage update; ascending port order lets the highest port win on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REGNUM; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (we[w] && (wa[w*AW +: AW] != PC_REG)) begin
                    rf[wa[w*AW +: AW]] <= wd[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] dat;

        assign a = ra[i*AW +: AW];

        // Read mux: PC alias over bypass (highest port) over stored value.
        always_comb begin
            dat = rf[a];
            for (int w = 0; w < NWRITE; w++) begin
                if (we[w] && (wa[w*AW +: AW] == a)) begin
                    dat = wd[w*WIDTH +: WIDTH];
                end
            end
            if (a == PC_REG) begin
                dat = pc + PC_ADD;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = dat;
        // A same-cycle write satisfies the read via bypass, so it never stalls.
        assign busy[i] = pending[a] & ~whit[a] & (a != PC_REG);
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench: directed vector table, reset corner sequence, randomized model compare.
module tb_pipe_regfile;
    import regfile_pkg::*;

    localparam int W   = 16;
    localparam int N   = 16;
    localparam int AW  = 4;
    localparam int NR  = 3;
    localparam int NW  = 2;
    localparam int OFF = 2;
    localparam logic [AW-1:0] PCR = 4'd15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  ra;
    logic [NR*W-1:0]   rd;
    logic [NR-1:0]     busy;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  wa;
    logic [NW*W-1:0]   wd;
    word_t             pc;
    logic              issue_en;
    reg_addr_t         issue_dst;

    pipe_regfile #(
        .WIDTH(W), .REGNUM(N), .AW(AW), .NREAD(NR), .NWRITE(NW), .PC_OFFSET(OFF)
    ) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .busy(busy), .we(we), .wa(wa),
        .wd(wd), .pc(pc), .issue_en(issue_en), .issue_dst(issue_dst)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Architectural reference state.
    word_t m_rf   [N];
    bit    m_pend [N];

    typedef struct {
        logic [NR*AW-1:0] ra;
        logic [NW-1:0]    we;
        logic [NW*AW-1:0] wa;
        logic [NW*W-1:0]  wd;
        word_t            pc;
        logic             ien;
        reg_addr_t        idst;
        logic [NR*W-1:0]  erd;
        logic [NR-1:0]    ebusy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [NR*AW-1:0] r, input logic [NW-1:0] e,
                                input logic [NW*AW-1:0] a, input logic [NW*W-1:0] d,
                                input word_t p, input logic ie, input reg_addr_t id,
                                input logic [NR*W-1:0] xr, input logic [NR-1:0] xb);
        vec_t v;
        v.ra = r; v.we = e; v.wa = a; v.wd = d; v.pc = p;
        v.ien = ie; v.idst = id; v.erd = xr; v.ebusy = xb;
        return v;
    endfunction

    function automatic word_t model_rd(input int p);
        reg_addr_t a = ra[p*AW +: AW];
        if (a == PCR) return word_t'(pc + OFF);
        for (int w = NW - 1; w >= 0; w--)
            if (we[w] && wa[w*AW +: AW] == a) return wd[w*W +: W];
        return m_rf[a];
    endfunction

    function automatic bit model_busy(input int p);
        reg_addr_t a = ra[p*AW +: AW];
        if (a == PCR) return 1'b0;
        for (int w = 0; w < NW; w++)
            if (we[w] && wa[w*AW +: AW] == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_check(input string tag);
        logic [NR*W-1:0] xr;
        logic [NR-1:0]   xb;
        for (int p = 0; p < NR; p++) begin
            xr[p*W +: W] = model_rd(p);
            xb[p]        = model_busy(p);
        end
        chk({tag, "_rd"}, 64'(rd), 64'(xr));
        chk({tag, "_busy"}, 64'(busy), 64'(xb));
    endtask

    task automatic model_clear();
        for (int r = 0; r < N; r++) begin
            m_rf[r] = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_tick();
        if (!rst) begin
            for (int w = 0; w < NW; w++)
                if (we[w] && wa[w*AW +: AW] != PCR) m_rf[wa[w*AW +: AW]] = wd[w*W +: W];
            for (int w = 0; w < NW; w++)
                if (we[w]) m_pend[wa[w*AW +: AW]] = 1'b0;
            if (issue_en && issue_dst != PCR) m_pend[issue_dst] = 1'b1;
        end
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; issue_en = 1'b0; issue_dst = '0;
    endtask

    // Check at the falling edge, then advance model across the rising edge.
    task automatic cyc(input string tag);
        @(negedge clk);
        model_check(tag);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    initial begin
        rst = 1'b1; ra = '0; pc = 16'h0100;
        idle();
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", 64'(rd), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All non-PC registers read zero on every port after reset
        for (int a = 0; a < 15; a++) begin
            ra = {NR{4'(a)}};
            @(negedge clk);
            chk("post_reset_rd", 64'(rd), 64'h0);
            chk("post_reset_busy", 64'(busy), 64'h0);
            @(posedge clk);
            #1;
        end

        // Directed vectors, one row per cycle
        tbl.push_back(mk({4'd15,4'd15,4'd15}, 2'b00, '0, '0, 16'h0100, 0, 0, {3{16'h0102}}, 3'b000));
        tbl.push_back(mk({4'd0,4'd0,4'd0}, 2'b01, {4'd0,4'd3}, {16'h0,16'hBEEF}, 16'h0100, 0, 0, '0, 3'b000));
        tbl.push_back(mk({4'd3,4'd0,4'd0}, 2'b00, '0, '0, 16'h0100, 0, 0, {16'hBEEF,16'h0,16'h0}, 3'b000));
        tbl.push_back(mk({4'd3,4'd0,4'd5}, 2'b01, {4'd0,4'd5}, {16'h0,16'h1234}, 16'h0100, 0, 0, {16'hBEEF,16'h0,16'h1234}, 3'b000));
        tbl.push_back(mk({4'd7,4'd5,4'd0}, 2'b11, {4'd7,4'd7}, {16'h5555,16'hAAAA}, 16'h0100, 0, 0, {16'h5555,16'h1234,16'h0}, 3'b000));
        tbl.push_back(mk({4'd7,4'd7,4'd7}, 2'b00, '0, '0, 16'h0100, 0, 0, {3{16'h5555}}, 3'b000));
        tbl.push_back(mk({4'd15,4'd15,4'd15}, 2'b01, {4'd0,4'd15}, {16'h0,16'hDEAD}, 16'h0200, 0, 0, {3{16'h0202}}, 3'b000));
        tbl.push_back(mk({4'd15,4'd15,4'd15}, 2'b00, '0, '0, 16'h0300, 0, 0, {3{16'h0302}}, 3'b000));
        tbl.push_back(mk({4'd4,4'd4,4'd4}, 2'b00, '0, '0, 16'h0300, 1, 4'd4, '0, 3'b000));
        tbl.push_back(mk({4'd4,4'd0,4'd4}, 2'b00, '0, '0, 16'h0300, 0, 0, '0, 3'b101));
        tbl.push_back(mk({4'd4,4'd4,4'd4}, 2'b00, '0, '0, 16'h0300, 0, 0, '0, 3'b111));
        tbl.push_back(mk({4'd4,4'd4,4'd4}, 2'b10, {4'd4,4'd0}, {16'h0042,16'h0}, 16'h0300, 0, 0, {3{16'h0042}}, 3'b000));
        tbl.push_back(mk({4'd4,4'd4,4'd4}, 2'b00, '0, '0, 16'h0300, 0, 0, {3{16'h0042}}, 3'b000));
        tbl.push_back(mk({4'd6,4'd6,4'd6}, 2'b01, {4'd0,4'd6}, {16'h0,16'h0066}, 16'h0300, 1, 4'd6, {3{16'h0066}}, 3'b000));
        tbl.push_back(mk({4'd6,4'd6,4'd6}, 2'b00, '0, '0, 16'h0300, 0, 0, {3{16'h0066}}, 3'b111));
        tbl.push_back(mk({4'd15,4'd15,4'd15}, 2'b00, '0, '0, 16'h0300, 1, 4'd15, {3{16'h0302}}, 3'b000));
        tbl.push_back(mk({4'd15,4'd15,4'd15}, 2'b00, '0, '0, 16'h0300, 0, 0, {3{16'h0302}}, 3'b000));
        tbl.push_back(mk({4'd6,4'd6,4'd6}, 2'b01, {4'd0,4'd6}, {16'h0,16'h0067}, 16'h0300, 0, 0, {3{16'h0067}}, 3'b000));
        tbl.push_back(mk({4'd6,4'd6,4'd6}, 2'b00, '0, '0, 16'h0300, 0, 0, {3{16'h0067}}, 3'b000));

        foreach (tbl[k]) begin
            ra = tbl[k].ra; we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd;
            pc = tbl[k].pc; issue_en = tbl[k].ien; issue_dst = tbl[k].idst;
            @(negedge clk);
            if (rd !== tbl[k].erd || busy !== tbl[k].ebusy)
                $display("  row %0d differs", k);
            chk("vec_rd", 64'(rd), 64'(tbl[k].erd));
            chk("vec_busy", 64'(busy), 64'(tbl[k].ebusy));
            @(posedge clk);
            model_tick();
            #1;
        end

        // Mid-stream async reset with pending r2, r9 and r1 = FFFF
        idle(); ra = '0;
        issue_en = 1'b1; issue_dst = 4'd2;
        cyc("pre_rst_a");
        issue_dst = 4'd9; we = 2'b01; wa = {4'd0,4'd1}; wd = {16'h0,16'hFFFF};
        cyc("pre_rst_b");
        idle();
        ra = {4'd9,4'd2,4'd1};
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(3'b110));
        chk("pre_rst_r1", 64'(rd[15:0]), 64'hFFFF);
        rst = 1'b1;
        #1;
        model_clear();
        chk("async_rst_busy", 64'(busy), 64'h0);
        chk("async_rst_r1", 64'(rd[15:0]), 64'h0);
        // Writes and issues while reset is held must not stick
        we = 2'b01; wa = {4'd0,4'd1}; wd = {16'h0,16'h1111};
        issue_en = 1'b1; issue_dst = 4'd2;
        @(posedge clk);
        #1;
        @(negedge clk);
        idle();
        rst = 1'b0;
        pc = 16'hFFFF;
        ra = {4'd15,4'd2,4'd1};
        #1;
        chk("rst_hold_rd", 64'(rd), 64'({16'h0001,16'h0,16'h0}));
        chk("rst_hold_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NR; p++) ra[p*AW +: AW] = 4'($urandom_range(0, 15));
            for (int w = 0; w < NW; w++) begin
                wa[w*AW +: AW] = 4'($urandom_range(0, 15));
                wd[w*W +: W]   = 16'($urandom);
            end
            we        = 2'($urandom);
            pc        = 16'($urandom);
            issue_en  = 1'($urandom);
            issue_dst = 4'($urandom_range(0, 15));
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
